// File: rtl/mac_accum_if.sv
// Beat-in / frame-result-out bundle for mac_accum.
// master drives beats and observes results; slave is the accumulator.
interface mac_accum_if #(
   parameter int unsigned LANES  = 16,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned CNT_W  = 16
);
   logic [LANES*DATA_W-1:0] pixelsIn;
   logic [LANES*DATA_W-1:0] weightsIn;
   logic                    validIn;
   logic                    lastIn;
   logic [ACC_W-1:0]        biasIn;
   logic [ACC_W-1:0]        sumOut;
   logic                    validOut;
   logic [CNT_W-1:0]        beatCount;
   logic                    satFlag;

   modport master (
      output pixelsIn, weightsIn, validIn, lastIn, biasIn,
      input  sumOut, validOut, beatCount, satFlag
   );

   modport slave (
      input  pixelsIn, weightsIn, validIn, lastIn, biasIn,
      output sumOut, validOut, beatCount, satFlag
   );
endinterface

// File: rtl/mac_accum.sv
// Pipelined multi-lane multiply-accumulate: register inputs, lane products, adder-tree sum,
// then a saturating frame accumulator that reports bias + sum of products per frame.
module mac_accum #(
   parameter int unsigned LANES  = 16,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ACC_W  = 32,
   parameter int unsigned SIGNED = 0,
   parameter int unsigned CNT_W  = 16
) (
   input  logic        clk,
   input  logic        rst,
   mac_accum_if.slave  bus
);
   localparam int unsigned PROD_W    = 2 * DATA_W;
   localparam int unsigned LOG2_L    = $clog2(LANES);
   localparam int unsigned TREE_W    = PROD_W + LOG2_L;
   localparam int unsigned NODES     = 2 * LANES - 1;
   localparam int unsigned BUS_W     = LANES * DATA_W;
   localparam bit          IS_SIGNED = (SIGNED != 0);

   typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_e;

   // stage 1
   logic [BUS_W-1:0]  pix_d, pix_q, wt_d, wt_q;
   logic              s1_valid_d, s1_valid_q, s1_last_d, s1_last_q;
   logic [ACC_W-1:0]  s1_bias_d, s1_bias_q;
   // stage 2
   logic [PROD_W-1:0] prod_d [LANES];
   logic [PROD_W-1:0] prod_q [LANES];
   logic              s2_valid_d, s2_valid_q, s2_last_d, s2_last_q;
   logic [ACC_W-1:0]  s2_bias_d, s2_bias_q;
   // stage 3
   logic [ACC_W-1:0]  tree_d, tree_q;
   logic              s3_valid_d, s3_valid_q, s3_last_d, s3_last_q;
   logic [ACC_W-1:0]  s3_bias_d, s3_bias_q;
   // accumulator and result registers
   state_e            state_d, state_q;
   logic [ACC_W-1:0]  acc_d, acc_q, sum_d, sum_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q, beat_d, beat_q;
   logic              sat_d, sat_q, satf_d, satf_q, vout_d, vout_q;
   logic [ACC_W-1:0]  add_base;
   logic [ACC_W:0]    add_out;

   function automatic logic [PROD_W-1:0] ext_op(input logic [DATA_W-1:0] x);
      if (IS_SIGNED) ext_op = PROD_W'($signed(x));
      else           ext_op = PROD_W'(x);
   endfunction

   function automatic logic [TREE_W-1:0] ext_prod(input logic [PROD_W-1:0] x);
      if (IS_SIGNED) ext_prod = TREE_W'($signed(x));
      else           ext_prod = TREE_W'(x);
   endfunction

   function automatic logic [ACC_W-1:0] ext_tree(input logic [TREE_W-1:0] x);
      if (IS_SIGNED) ext_tree = ACC_W'($signed(x));
      else           ext_tree = ACC_W'(x);
   endfunction

   // Returns {clamped, result}; one extra bit of headroom exposes the overflow.
   function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      if (IS_SIGNED) begin
         s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
         if (s[ACC_W] != s[ACC_W-1])
            sat_add = {1'b1, s[ACC_W], {(ACC_W-1){~s[ACC_W]}}};
         else
            sat_add = {1'b0, s[ACC_W-1:0]};
      end else begin
         s = {1'b0, a} + {1'b0, b};
         if (s[ACC_W]) sat_add = {1'b1, {ACC_W{1'b1}}};
         else          sat_add = {1'b0, s[ACC_W-1:0]};
      end
   endfunction

   always_comb begin : stage1_next
      pix_d      = bus.pixelsIn;
      wt_d       = bus.weightsIn;
      s1_valid_d = bus.validIn;
      s1_last_d  = bus.lastIn;
      s1_bias_d  = bus.biasIn;
   end

   // Lane k occupies the k-th DATA_W slice counting from the MSB end.
   always_comb begin : stage2_next
      for (int k = 0; k < int'(LANES); k++) begin
         prod_d[k] = ext_op(pix_q[DATA_W*(LANES-k)-1 -: DATA_W])
                   * ext_op(wt_q[DATA_W*(LANES-k)-1 -: DATA_W]);
      end
      s2_valid_d = s1_valid_q;
      s2_last_d  = s1_last_q;
      s2_bias_d  = s1_bias_q;
   end

   // Heap-ordered binary tree: node i sums children 2i+1 and 2i+2, leaves hold products.
   always_comb begin : stage3_next
      logic [TREE_W-1:0] node [NODES];
      for (int i = 0; i < int'(LANES); i++) node[int'(LANES)-1+i] = ext_prod(prod_q[i]);
      for (int i = int'(LANES) - 2; i >= 0; i--) node[i] = node[2*i+1] + node[2*i+2];
      tree_d     = ext_tree(node[0]);
      s3_valid_d = s2_valid_q;
      s3_last_d  = s2_last_q;
      s3_bias_d  = s2_bias_q;
   end

   always_comb begin : accum_next
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      sat_d    = sat_q;
      sum_d    = sum_q;
      beat_d   = beat_q;
      satf_d   = satf_q;
      vout_d   = 1'b0;
      add_base = (state_q == ST_IDLE) ? s3_bias_q : acc_q;
      add_out  = sat_add(add_base, tree_q);
      if (s3_valid_q) begin
         acc_d = add_out[ACC_W-1:0];
         if (state_q == ST_IDLE) begin
            cnt_d = CNT_W'(1);
            sat_d = add_out[ACC_W];
         end else begin
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
            sat_d = sat_q | add_out[ACC_W];
         end
         if (s3_last_q) begin
            state_d = ST_IDLE;
            vout_d  = 1'b1;
            sum_d   = acc_d;
            beat_d  = cnt_d;
            satf_d  = sat_d;
         end else begin
            state_d = ST_ACCUM;
         end
      end
   end

   // Control state: valid tags, FSM, accumulator and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s3_valid_q <= 1'b0;
         state_q    <= ST_IDLE;
         acc_q      <= '0;
         cnt_q      <= '0;
         sat_q      <= 1'b0;
         sum_q      <= '0;
         beat_q     <= '0;
         satf_q     <= 1'b0;
         vout_q     <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s3_valid_q <= s3_valid_d;
         state_q    <= state_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         sat_q      <= sat_d;
         sum_q      <= sum_d;
         beat_q     <= beat_d;
         satf_q     <= satf_d;
         vout_q     <= vout_d;
      end
   end

   // Datapath payload is only consumed when its valid tag is set.
   always_ff @(posedge clk) begin
      pix_q     <= pix_d;
      wt_q      <= wt_d;
      s1_last_q <= s1_last_d;
      s1_bias_q <= s1_bias_d;
      prod_q    <= prod_d;
      s2_last_q <= s2_last_d;
      s2_bias_q <= s2_bias_d;
      tree_q    <= tree_d;
      s3_last_q <= s3_last_d;
      s3_bias_q <= s3_bias_d;
   end

   assign bus.sumOut    = sum_q;
   assign bus.validOut  = vout_q;
   assign bus.beatCount = beat_q;
   assign bus.satFlag   = satf_q;
endmodule

// File: tb/tb_mac_accum.sv
// Bench for mac_accum: three instances (unsigned/32, signed/32, unsigned/20) share one stimulus
// stream and are compared every cycle against a frame-level arithmetic model.
module tb_mac_accum;
   localparam int unsigned LANES  = 16;
   localparam int unsigned DATA_W = 8;
   localparam int unsigned BUS_W  = LANES * DATA_W;
   localparam int NM = 3;

   logic clk = 1'b0;
   logic rst;
   logic [BUS_W-1:0] pix_in, wt_in;
   logic valid_in, last_in;
   logic [31:0] bias_in;

   always #5 clk = ~clk;

   mac_accum_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .CNT_W(16)) bus_u ();
   mac_accum_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .CNT_W(16)) bus_s ();
   mac_accum_if #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(20), .CNT_W(16)) bus_n ();

   assign bus_u.pixelsIn = pix_in;  assign bus_u.weightsIn = wt_in;
   assign bus_u.validIn  = valid_in; assign bus_u.lastIn   = last_in;
   assign bus_u.biasIn   = bias_in;
   assign bus_s.pixelsIn = pix_in;  assign bus_s.weightsIn = wt_in;
   assign bus_s.validIn  = valid_in; assign bus_s.lastIn   = last_in;
   assign bus_s.biasIn   = bias_in;
   assign bus_n.pixelsIn = pix_in;  assign bus_n.weightsIn = wt_in;
   assign bus_n.validIn  = valid_in; assign bus_n.lastIn   = last_in;
   assign bus_n.biasIn   = bias_in[19:0];

   mac_accum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .SIGNED(0), .CNT_W(16))
      u_dut_u (.clk(clk), .rst(rst), .bus(bus_u));
   mac_accum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(32), .SIGNED(1), .CNT_W(16))
      u_dut_s (.clk(clk), .rst(rst), .bus(bus_s));
   mac_accum #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(20), .SIGNED(0), .CNT_W(16))
      u_dut_n (.clk(clk), .rst(rst), .bus(bus_n));

   typedef struct {
      logic [BUS_W-1:0] pix;
      logic [BUS_W-1:0] wt;
      logic [31:0]      bias;
      bit               last;
      int               due;
   } beat_t;

   bit     m_sgn [NM] = '{1'b0, 1'b1, 1'b0};
   int     m_w   [NM] = '{32, 32, 20};
   bit     m_in  [NM];
   longint m_acc [NM];
   int     m_cnt [NM];
   bit     m_sat [NM];
   logic [63:0] exp_sum [NM];
   logic [63:0] exp_cnt [NM];
   logic        exp_sat [NM];
   logic        exp_v   [NM];
   int     pc [NM];
   beat_t  pend [$];
   beat_t  nb;
   int     edge_n = 0;
   bit     chk_en = 1'b0;
   int     cmp_cnt = 0;
   int     err_cnt = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      cmp_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic grab(input int m, output logic v, output logic [63:0] s,
                       output logic [63:0] c, output logic sf);
      case (m)
         0:       begin v = bus_u.validOut; s = 64'(bus_u.sumOut); c = 64'(bus_u.beatCount); sf = bus_u.satFlag; end
         1:       begin v = bus_s.validOut; s = 64'(bus_s.sumOut); c = 64'(bus_s.beatCount); sf = bus_s.satFlag; end
         default: begin v = bus_n.validOut; s = 64'(bus_n.sumOut); c = 64'(bus_n.beatCount); sf = bus_n.satFlag; end
      endcase
   endtask

   // Frame arithmetic straight from the rules: dot product, bias on first beat, clamp, count.
   task automatic apply(input int m, input beat_t b);
      longint dot, bv, lo, hi, mk, t, pv, wv;
      logic [7:0] pb, wb;
      bit s;
      mk  = (longint'(1) << m_w[m]) - 1;
      dot = 0;
      for (int k = 0; k < int'(LANES); k++) begin
         pb = b.pix[8*k +: 8];
         wb = b.wt[8*k +: 8];
         pv = longint'(pb);
         wv = longint'(wb);
         if (m_sgn[m] && pb[7]) pv -= 256;
         if (m_sgn[m] && wb[7]) wv -= 256;
         dot += pv * wv;
      end
      bv = longint'(b.bias) & mk;
      if (m_sgn[m] && bv[m_w[m]-1]) bv -= (longint'(1) << m_w[m]);
      if (m_sgn[m]) begin
         lo = -(longint'(1) << (m_w[m] - 1));
         hi = (longint'(1) << (m_w[m] - 1)) - 1;
      end else begin
         lo = 0;
         hi = mk;
      end
      t = (m_in[m] ? m_acc[m] : bv) + dot;
      s = (t < lo) || (t > hi);
      if (t < lo) t = lo;
      else if (t > hi) t = hi;
      m_sat[m] = m_in[m] ? (m_sat[m] | s) : s;
      m_cnt[m] = !m_in[m] ? 1 : ((m_cnt[m] == 65535) ? 65535 : m_cnt[m] + 1);
      m_acc[m] = t;
      if (b.last) begin
         exp_sum[m] = 64'(t & mk);
         exp_cnt[m] = 64'(m_cnt[m]);
         exp_sat[m] = m_sat[m];
         exp_v[m]   = 1'b1;
         m_in[m]    = 1'b0;
      end else begin
         m_in[m] = 1'b1;
      end
   endtask

   // Model: every accepted beat takes effect on the third edge after it was sampled.
   always @(posedge clk) begin
      edge_n++;
      if (rst) begin
         pend.delete();
         for (int m = 0; m < NM; m++) begin
            m_in[m] = 1'b0; m_acc[m] = 0; m_cnt[m] = 0; m_sat[m] = 1'b0;
            exp_sum[m] = '0; exp_cnt[m] = '0; exp_sat[m] = 1'b0; exp_v[m] = 1'b0;
         end
         chk_en = 1'b1;
      end else begin
         for (int m = 0; m < NM; m++) exp_v[m] = 1'b0;
         while (pend.size() > 0 && pend[0].due == edge_n) begin
            nb = pend.pop_front();
            for (int m = 0; m < NM; m++) apply(m, nb);
         end
         if (valid_in) begin
            nb.pix = pix_in; nb.wt = wt_in; nb.bias = bias_in;
            nb.last = last_in; nb.due = edge_n + 3;
            pend.push_back(nb);
         end
      end
   end

   always @(negedge clk) begin
      logic v, sf;
      logic [63:0] s, c;
      if (chk_en) begin
         for (int m = 0; m < NM; m++) begin
            grab(m, v, s, c, sf);
            check($sformatf("dut%0d.validOut", m), 64'(v), 64'(exp_v[m]));
            check($sformatf("dut%0d.sumOut", m), s, exp_sum[m]);
            check($sformatf("dut%0d.beatCount", m), c, exp_cnt[m]);
            check($sformatf("dut%0d.satFlag", m), 64'(sf), 64'(exp_sat[m]));
            if (v === 1'b1) pc[m]++;
         end
      end
   end

   task automatic set_in(input bit v, input bit l, input logic [7:0] p, input logic [7:0] w,
                         input logic [31:0] b);
      valid_in = v; last_in = l; pix_in = {LANES{p}}; wt_in = {LANES{w}}; bias_in = b;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input bit l, input logic [7:0] p, input logic [7:0] w, input logic [31:0] b);
      set_in(1'b1, l, p, w, b);
      step();
   endtask

   task automatic idle(input int n);
      set_in(1'b0, 1'b0, 8'd0, 8'd0, 32'd0);
      repeat (n) step();
   endtask

   // Waits (bounded) for a result pulse on instance m; returns negedges waited.
   task automatic wait_pulse(input int m, output int waited, output logic [63:0] s,
                             output logic [63:0] c, output logic sf);
      logic v;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
         grab(m, v, s, c, sf);
      end while (v !== 1'b1 && waited < 20);
      if (v !== 1'b1) check($sformatf("dut%0d.pulse_timeout", m), 64'(v), 64'd1);
   endtask

   function automatic logic [7:0] rand_op();
      case ($urandom_range(0, 5))
         0:       rand_op = 8'h00;
         1:       rand_op = 8'hFF;
         2:       rand_op = 8'h80;
         3:       rand_op = 8'h7F;
         4:       rand_op = 8'h01;
         default: rand_op = 8'($urandom);
      endcase
   endfunction

   initial begin
      int w, p0;
      logic [63:0] s, c;
      logic sf, v;
      logic [31:0] lit32;
      rst = 1'b1;
      set_in(1'b0, 1'b0, 8'd0, 8'd0, 32'd0);
      repeat (2) step();
      rst = 1'b0;
      check("reset.sumOut", 64'(bus_u.sumOut), 64'd0);
      check("reset.validOut", 64'(bus_u.validOut), 64'd0);
      check("reset.beatCount", 64'(bus_u.beatCount), 64'd0);
      check("reset.satFlag", 64'(bus_u.satFlag), 64'd0);
      idle(2);

      // single full-scale beat, latency 3
      beat(1'b1, 8'hFF, 8'hFF, 32'd0);
      idle(0);
      wait_pulse(0, w, s, c, sf);
      check("single.latency", 64'(w), 64'd4);
      check("single.sumOut", s, 64'd1040400);
      check("single.beatCount", c, 64'd1);
      check("single.satFlag", 64'(sf), 64'd0);
      check("single.model_sum", exp_sum[0], 64'd1040400);
      idle(3);

      // four beats with a gap; bias only taken from the first beat
      p0 = pc[0];
      beat(1'b0, 8'd1, 8'd1, 32'd10);
      beat(1'b0, 8'd1, 8'd1, 32'd99);
      idle(1);
      beat(1'b0, 8'd1, 8'd1, 32'd77);
      beat(1'b1, 8'd1, 8'd1, 32'd55);
      idle(0);
      wait_pulse(0, w, s, c, sf);
      check("gap.sumOut", s, 64'd74);
      check("gap.beatCount", c, 64'd4);
      check("gap.model_sum", exp_sum[0], 64'd74);
      idle(6);
      check("gap.pulses", 64'(pc[0] - p0), 64'd1);

      // signed single beat
      beat(1'b1, 8'h80, 8'h7F, 32'hFFFF_FFFC);
      idle(0);
      wait_pulse(1, w, s, c, sf);
      lit32 = -32'd260100;
      check("signed.sumOut", s, 64'(lit32));
      check("signed.satFlag", 64'(sf), 64'd0);
      check("signed.model_sum", exp_sum[1], 64'(lit32));
      idle(3);

      // narrow accumulator saturation, then a clean frame
      beat(1'b0, 8'hFF, 8'hFF, 32'd0);
      beat(1'b1, 8'hFF, 8'hFF, 32'd0);
      idle(0);
      wait_pulse(2, w, s, c, sf);
      check("sat.sumOut", s, 64'd1048575);
      check("sat.beatCount", c, 64'd2);
      check("sat.satFlag", 64'(sf), 64'd1);
      check("sat.model_flag", 64'(exp_sat[2]), 64'd1);
      idle(2);
      beat(1'b1, 8'd1, 8'd1, 32'd0);
      idle(0);
      wait_pulse(2, w, s, c, sf);
      check("sat_next.sumOut", s, 64'd16);
      check("sat_next.satFlag", 64'(sf), 64'd0);
      idle(3);

      // back-to-back single-beat frames
      beat(1'b1, 8'd1, 8'd1, 32'd0);
      beat(1'b1, 8'd1, 8'd1, 32'd1);
      beat(1'b1, 8'd1, 8'd1, 32'd2);
      idle(0);
      wait_pulse(0, w, s, c, sf);
      check("b2b0.sumOut", s, 64'd16);
      @(negedge clk);
      grab(0, v, s, c, sf);
      check("b2b1.validOut", 64'(v), 64'd1);
      check("b2b1.sumOut", s, 64'd17);
      @(negedge clk);
      grab(0, v, s, c, sf);
      check("b2b2.validOut", 64'(v), 64'd1);
      check("b2b2.sumOut", s, 64'd18);
      @(negedge clk);
      grab(0, v, s, c, sf);
      check("b2b3.validOut", 64'(v), 64'd0);
      idle(3);

      // reset mid-frame discards partial frame and in-flight beats
      p0 = pc[0];
      beat(1'b0, 8'd1, 8'd1, 32'd0);
      beat(1'b0, 8'd1, 8'd1, 32'd0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      check("midrst.sumOut", 64'(bus_u.sumOut), 64'd0);
      check("midrst.validOut", 64'(bus_u.validOut), 64'd0);
      beat(1'b1, 8'd1, 8'd1, 32'd0);
      idle(0);
      wait_pulse(0, w, s, c, sf);
      check("midrst.new_sum", s, 64'd16);
      check("midrst.new_cnt", c, 64'd1);
      idle(6);
      check("midrst.pulses", 64'(pc[0] - p0), 64'd1);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         rst      = ($urandom_range(0, 299) == 0);
         valid_in = ($urandom_range(0, 9) < 7);
         last_in  = ($urandom_range(0, 4) == 0);
         for (int k = 0; k < int'(LANES); k++) begin
            pix_in[8*k +: 8] = rand_op();
            wt_in[8*k +: 8]  = rand_op();
         end
         bias_in = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
         step();
      end
      rst = 1'b0;
      idle(10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
      $finish;
   end
endmodule
